unidade_load_store: RTL and testbench
=====================================

# unidade_load_store

Load/store unit between the CPU execute stage and the word-organised data memory. Converts byte-addressed byte/halfword/word loads and stores into whole-word memory accesses. Sub-word stores run as read-modify-write sequences; loads return lane-extracted, optionally sign-extended data. The CPU is stalled through `ocupado` until a one-cycle `pronto` pulse.

## Interface
- `MEM_SIZE`, 150: data memory depth in 32-bit words; informational, no range check.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  1: request valid; sampled only in IDLE.
- `op_escrita`  in  1: 1 = store, 0 = load.
- `tamanho`  in  2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- `sinal`  in  1: 1 = sign-extend sub-word loads, 0 = zero-extend.
- `endereco_byte`  in  32: byte address.
- `dado_cpu`  in  32: store data, right-aligned.
- `dado_carregado`  out  32: load result, valid while `pronto`=1 and held until the next load completes.
- `pronto`  out  1: one-cycle completion pulse.
- `ocupado`  out  1: 1 in every state except IDLE.
- `erro_alinhamento`  out  1: misalignment flag; present only with `LS_ALIGN_CHECK_EN`.
- `mem_endereco`  out  32: word index, equal to captured `endereco_byte[31:2]` zero-extended.
- `mem_write`  out  1: memory write strobe.
- `mem_dado_escrito`  out  32: word to write.
- `mem_dado_lido`  in  32: memory read data, combinational from `mem_endereco` in the same cycle.

## Operation
- FSM states and transitions:
  - IDLE: `req`=1 captures address, op, size, sign and data.
    - Load or sub-word store: go to LEITURA.
    - Word store: go to ESCRITA.
  - LEITURA: sample `mem_dado_lido`.
    - Load: register the extracted result, then go to FIM.
    - Sub-word store: register the merged word, then go to ESCRITA.
  - ESCRITA: `mem_write`=1 with `mem_dado_escrito` driven; go to FIM.
  - FIM: `pronto`=1; go to IDLE.
- Lanes are little-endian.
  - Byte: lane `b = endereco_byte[1:0]` occupies bits [8b+7:8b].
  - Halfword: `endereco_byte[1]` selects [15:0] or [31:16].
  - Word: all 32 bits.
- Load extension:
  - `sinal`=1: replicate the lane MSB into the upper bits.
  - `sinal`=0: fill the upper bits with 0.
  - Word loads ignore `sinal`.
- Store merge: replace only the selected lane of the read word with `dado_cpu[7:0]` or `dado_cpu[15:0]`. All other bytes keep their read value.
- `mem_write` = (state==ESCRITA) && !`reset`. Reset asserted during ESCRITA therefore suppresses the write.
- A `req` arriving in any non-IDLE state is ignored. The CPU holds `req` until it sees `pronto`.
- Without the macro, misaligned addresses are not checked: low address bits only select lanes, and the access uses `endereco_byte[31:2]`.

## Timing
- Request accepted at edge N.
- Latency from acceptance to `pronto`:
  - Load: `pronto` in cycle N+2.
  - Word store: `mem_write` in cycle N+1, `pronto` in N+2.
  - Sub-word store: read in N+1, `mem_write` in N+2, `pronto` in N+3.
- Earliest next acceptance is the cycle after `pronto`, when the FSM is back in IDLE.
- Reset values: `dado_carregado`=0, `pronto`=0, `ocupado`=0, `mem_write`=0, `mem_endereco`=0, `mem_dado_escrito`=0, `erro_alinhamento`=0.
- Reset mid-operation: the FSM returns to IDLE at the next edge and the operation is discarded without `pronto`.

## Configuration
- Macro: `LS_ALIGN_CHECK_EN`.
- With the macro, misalignment is checked at acceptance. Misaligned means:
  - halfword with `endereco_byte[0]`=1, or
  - word with `endereco_byte[1:0]`≠0.
- On misalignment, go directly to FIM with `pronto`=1 and `erro_alinhamento`=1 for that cycle. No memory write occurs and `dado_carregado` is unchanged.
- Without the macro, the `erro_alinhamento` port is absent and no check is made.

## Structure
- Package `pacote_load_store`: `tamanho` encodings (TAM_BYTE, TAM_MEIA, TAM_PALAVRA) and the FSM state encodings.
- Sub-module `alinhador_bytes`: purely combinational, holding both lane extraction with sign/zero extension and store merge. Instantiated once.

## Test plan
- Word store/load: store 0xDEADBEEF at byte addr 0x10 → `mem_write` in N+1 with `mem_endereco`=4 and `pronto` in N+2. A later word load from 0x10 returns 0xDEADBEEF in N+2.
- Byte store merge: memory word 1 = 0x11223344; store byte 0xAA at 0x06 → word 1 becomes 0x11AA3344, `pronto` at N+3.
- Sign extension: word = 0x0080FF7F. Expected results:
  - load byte addr 1, `sinal`=1 → 0xFFFFFFFF
  - load byte addr 1, `sinal`=0 → 0x000000FF
  - load half addr 2, `sinal`=1 → 0x00000080
- Busy/back-to-back: `req` held continuously across two loads → the second is accepted only the cycle after the first `pronto`. No `req` is accepted while `ocupado`=1.
- Reset during ESCRITA of a byte store → `mem_write`=0 in that cycle, memory unchanged, no `pronto`, next cycle IDLE with all outputs at reset values.
- `LS_ALIGN_CHECK_EN` on: word store at 0x0A → `pronto` and `erro_alinhamento` in N+1, no `mem_write`. Macro off: same request writes word 2.

Source files
------------

// File: rtl/unidade_load_store_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and alignment helpers.
package pacote_load_store;

    typedef enum logic [1:0] {
        TAM_BYTE      = 2'b00,
        TAM_MEIA      = 2'b01,
        TAM_PALAVRA   = 2'b10,
        TAM_RESERVADO = 2'b11
    } tamanho_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LEITURA = 2'b01,
        ESCRITA = 2'b10,
        FIM     = 2'b11
    } estado_t;

    // Byte and halfword accesses touch only part of a word and need read-modify-write.
    function automatic logic eh_sub_palavra(tamanho_t tamanho);
        return (tamanho == TAM_BYTE) || (tamanho == TAM_MEIA);
    endfunction

    // The reserved size encoding behaves as a word access.
    function automatic logic desalinhado(tamanho_t tamanho, logic [1:0] deslocamento);
        logic resultado;
        case (tamanho)
            TAM_BYTE: resultado = 1'b0;
            TAM_MEIA: resultado = deslocamento[0];
            default:  resultado = (deslocamento != 2'b00);
        endcase
        return resultado;
    endfunction

endpackage

// File: rtl/unidade_load_store_if.sv
// CPU request/response and data-memory bus of the load/store unit.
// erro_alinhamento exists only when LS_ALIGN_CHECK_EN is defined.
interface unidade_load_store_if;

    logic        req;
    logic        op_escrita;
    logic [1:0]  tamanho;
    logic        sinal;
    logic [31:0] endereco_byte;
    logic [31:0] dado_cpu;
    logic [31:0] dado_carregado;
    logic        pronto;
    logic        ocupado;
`ifdef LS_ALIGN_CHECK_EN
    logic        erro_alinhamento;
`endif
    logic [31:0] mem_endereco;
    logic        mem_write;
    logic [31:0] mem_dado_escrito;
    logic [31:0] mem_dado_lido;

    modport slave (
        input  req, op_escrita, tamanho, sinal, endereco_byte, dado_cpu, mem_dado_lido,
`ifdef LS_ALIGN_CHECK_EN
        output erro_alinhamento,
`endif
        output dado_carregado, pronto, ocupado, mem_endereco, mem_write, mem_dado_escrito
    );

    modport master (
        output req, op_escrita, tamanho, sinal, endereco_byte, dado_cpu, mem_dado_lido,
`ifdef LS_ALIGN_CHECK_EN
        input  erro_alinhamento,
`endif
        input  dado_carregado, pronto, ocupado, mem_endereco, mem_write, mem_dado_escrito
    );

endinterface

// File: rtl/unidade_load_store_alinhador.sv
// Combinational lane logic: extracts and extends load data, and merges sub-word store data
// into the word read from memory (little-endian lanes).
module alinhador_bytes
    import pacote_load_store::*;
(
    input  logic [31:0] palavra_lida,
    input  logic [1:0]  deslocamento,
    input  tamanho_t    tamanho,
    input  logic        sinal,
    input  logic [31:0] dado_cpu,
    output logic [31:0] dado_extraido,
    output logic [31:0] palavra_mesclada
);

    logic [7:0]  byte_lido;
    logic [15:0] meia_lida;

    always_comb begin
        byte_lido        = palavra_lida[{deslocamento, 3'b000} +: 8];
        meia_lida        = palavra_lida[{deslocamento[1], 4'b0000} +: 16];
        dado_extraido    = palavra_lida;
        palavra_mesclada = palavra_lida;
        case (tamanho)
            TAM_BYTE: begin
                dado_extraido = {{24{sinal & byte_lido[7]}}, byte_lido};
                palavra_mesclada[{deslocamento, 3'b000} +: 8] = dado_cpu[7:0];
            end
            TAM_MEIA: begin
                dado_extraido = {{16{sinal & meia_lida[15]}}, meia_lida};
                palavra_mesclada[{deslocamento[1], 4'b0000} +: 16] = dado_cpu[15:0];
            end
            default: begin
                dado_extraido    = palavra_lida;
                palavra_mesclada = dado_cpu;
            end
        endcase
    end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit: turns byte/halfword/word CPU accesses into whole-word memory accesses.
// Optional misalignment detection is enabled with the LS_ALIGN_CHECK_EN macro.
module unidade_load_store
    import pacote_load_store::*;
#(
    parameter int MEM_SIZE = 150
) (
    input logic                 clock,
    input logic                 reset,
    unidade_load_store_if.slave bus
);

    estado_t     estado_q, estado_d;
    logic [31:0] endereco_q, endereco_d;
    logic        op_escrita_q, op_escrita_d;
    tamanho_t    tamanho_q, tamanho_d;
    logic        sinal_q, sinal_d;
    logic [31:0] escrita_q, escrita_d;
    logic [31:0] carregado_q, carregado_d;
    logic [31:0] dado_extraido;
    logic [31:0] palavra_mesclada;
`ifdef LS_ALIGN_CHECK_EN
    logic        erro_q, erro_d;
`endif

    alinhador_bytes u_alinhador (
        .palavra_lida     (bus.mem_dado_lido),
        .deslocamento     (endereco_q[1:0]),
        .tamanho          (tamanho_q),
        .sinal            (sinal_q),
        .dado_cpu         (escrita_q),
        .dado_extraido    (dado_extraido),
        .palavra_mesclada (palavra_mesclada)
    );

    // escrita_q holds the raw store data until LEITURA replaces it with the merged word.
    always_comb begin
        estado_d     = estado_q;
        endereco_d   = endereco_q;
        op_escrita_d = op_escrita_q;
        tamanho_d    = tamanho_q;
        sinal_d      = sinal_q;
        escrita_d    = escrita_q;
        carregado_d  = carregado_q;
`ifdef LS_ALIGN_CHECK_EN
        erro_d       = 1'b0;
`endif
        case (estado_q)
            IDLE: begin
                if (bus.req) begin
                    endereco_d   = bus.endereco_byte;
                    op_escrita_d = bus.op_escrita;
                    tamanho_d    = tamanho_t'(bus.tamanho);
                    sinal_d      = bus.sinal;
                    escrita_d    = bus.dado_cpu;
`ifdef LS_ALIGN_CHECK_EN
                    if (desalinhado(tamanho_t'(bus.tamanho), bus.endereco_byte[1:0])) begin
                        erro_d   = 1'b1;
                        estado_d = FIM;
                    end else
`endif
                    if (!bus.op_escrita || eh_sub_palavra(tamanho_t'(bus.tamanho))) begin
                        estado_d = LEITURA;
                    end else begin
                        estado_d = ESCRITA;
                    end
                end
            end
            LEITURA: begin
                if (op_escrita_q) begin
                    escrita_d = palavra_mesclada;
                    estado_d  = ESCRITA;
                end else begin
                    carregado_d = dado_extraido;
                    estado_d    = FIM;
                end
            end
            ESCRITA: estado_d = FIM;
            FIM:     estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= IDLE;
            endereco_q   <= '0;
            op_escrita_q <= 1'b0;
            tamanho_q    <= TAM_BYTE;
            sinal_q      <= 1'b0;
            escrita_q    <= '0;
            carregado_q  <= '0;
`ifdef LS_ALIGN_CHECK_EN
            erro_q       <= 1'b0;
`endif
        end else begin
            estado_q     <= estado_d;
            endereco_q   <= endereco_d;
            op_escrita_q <= op_escrita_d;
            tamanho_q    <= tamanho_d;
            sinal_q      <= sinal_d;
            escrita_q    <= escrita_d;
            carregado_q  <= carregado_d;
`ifdef LS_ALIGN_CHECK_EN
            erro_q       <= erro_d;
`endif
        end
    end

    // The write strobe is gated by reset so an operation aborted in ESCRITA never lands.
    assign bus.mem_write        = (estado_q == ESCRITA) && !reset;
    assign bus.mem_endereco     = {2'b00, endereco_q[31:2]};
    assign bus.mem_dado_escrito = escrita_q;
    assign bus.dado_carregado   = carregado_q;
    assign bus.pronto           = (estado_q == FIM);
    assign bus.ocupado          = (estado_q != IDLE);
`ifdef LS_ALIGN_CHECK_EN
    assign bus.erro_alinhamento = erro_q;
`endif

endmodule

// File: tb/tb_unidade_load_store.sv
// Self-checking bench for unidade_load_store: directed scenarios plus random accesses
// compared against an arithmetic model of memory and load results.
module tb_unidade_load_store;

    localparam int MEM_SIZE = 150;

    logic        clock;
    logic        reset;
    logic        mem_init;
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] mem     [MEM_SIZE];
    logic [31:0] ref_mem [MEM_SIZE];
    logic [31:0] last_load;

    unidade_load_store_if bus ();

    unidade_load_store #(.MEM_SIZE(MEM_SIZE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] init_word(int i);
        return 32'h9E37_79B9 * (i + 1);
    endfunction

    assign bus.mem_dado_lido = (bus.mem_endereco < MEM_SIZE) ? mem[bus.mem_endereco[7:0]] : 32'h0;

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_word(i);
        end else if (bus.mem_write && bus.mem_endereco < MEM_SIZE) begin
            mem[bus.mem_endereco[7:0]] <= bus.mem_dado_escrito;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_misaligned(logic [1:0] t, logic [31:0] a);
`ifdef LS_ALIGN_CHECK_EN
        return (t == 2'd1 && (a % 2) != 0) || (t >= 2'd2 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(logic [1:0] t, logic s, logic [31:0] w, logic [31:0] a);
        logic [31:0] v;
        if (t == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (s && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (t == 2'd1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (s && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(logic [1:0] t, logic [31:0] w, logic [31:0] a, logic [31:0] d);
        logic [31:0] sh, mask;
        if (t == 2'd0) begin
            sh   = 8 * (a % 4);
            mask = 32'hFF << sh;
            return (w & ~mask) | ((d & 32'hFF) << sh);
        end else if (t == 2'd1) begin
            sh   = 16 * ((a / 2) % 2);
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    // One complete request/response transaction, checked cycle by cycle against the model.
    task automatic apply_stimulus(input string tag, input logic w, input logic [1:0] t, input logic s,
                                  input logic [31:0] a, input logic [31:0] d);
        int          idx, cyc, pronto_at, wr_at, lat_exp, wr_exp;
        logic        mis;
        logic [31:0] store_exp, load_exp;
        idx       = int'(a >> 2);
        mis       = model_misaligned(t, a);
        lat_exp   = mis ? 1 : ((w && t < 2'd2) ? 3 : 2);
        wr_exp    = (!w || mis) ? 0 : ((t < 2'd2) ? 2 : 1);
        store_exp = model_store(t, ref_mem[idx], a, d);
        load_exp  = (!w && !mis) ? model_load(t, s, ref_mem[idx], a) : last_load;

        bus.req           = 1'b1;
        bus.op_escrita    = w;
        bus.tamanho       = t;
        bus.sinal         = s;
        bus.endereco_byte = a;
        bus.dado_cpu      = d;
        cyc       = 0;
        pronto_at = 0;
        wr_at     = 0;
        while (pronto_at == 0 && cyc < 8) begin
            tick();
            cyc++;
            check_output({tag, " ocupado"}, 32'(bus.ocupado), 32'd1);
            if (bus.mem_write) begin
                wr_at = cyc;
                check_output({tag, " mem_endereco"}, bus.mem_endereco, 32'(idx));
                check_output({tag, " mem_dado_escrito"}, bus.mem_dado_escrito, store_exp);
            end
            if (bus.pronto) pronto_at = cyc;
`ifdef LS_ALIGN_CHECK_EN
            check_output({tag, " erro_alinhamento"}, 32'(bus.erro_alinhamento), 32'(bus.pronto && mis));
`endif
        end
        bus.req = 1'b0;
        check_output({tag, " pronto latency"}, 32'(pronto_at), 32'(lat_exp));
        check_output({tag, " write cycle"}, 32'(wr_at), 32'(wr_exp));
        check_output({tag, " dado_carregado"}, bus.dado_carregado, load_exp);
        if (w && !mis) ref_mem[idx] = store_exp;
        last_load = load_exp;

        tick();
        check_output({tag, " idle ocupado"}, 32'(bus.ocupado), 32'd0);
        check_output({tag, " idle pronto"}, 32'(bus.pronto), 32'd0);
        check_output({tag, " memory word"}, mem[idx], ref_mem[idx]);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " dado_carregado"}, bus.dado_carregado, 32'h0);
        check_output({tag, " pronto"}, 32'(bus.pronto), 32'd0);
        check_output({tag, " ocupado"}, 32'(bus.ocupado), 32'd0);
        check_output({tag, " mem_write"}, 32'(bus.mem_write), 32'd0);
        check_output({tag, " mem_endereco"}, bus.mem_endereco, 32'h0);
        check_output({tag, " mem_dado_escrito"}, bus.mem_dado_escrito, 32'h0);
`ifdef LS_ALIGN_CHECK_EN
        check_output({tag, " erro_alinhamento"}, 32'(bus.erro_alinhamento), 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] exp1, exp2;
        reset             = 1'b1;
        mem_init          = 1'b1;
        bus.req           = 1'b0;
        bus.op_escrita    = 1'b0;
        bus.tamanho       = 2'd0;
        bus.sinal         = 1'b0;
        bus.endereco_byte = 32'h0;
        bus.dado_cpu      = 32'h0;
        last_load         = 32'h0;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_word(i);
        tick();
        tick();
        reset    = 1'b0;
        mem_init = 1'b0;
        check_reset_values("reset");

        // Word store then word load at byte address 0x10 (word 4).
        apply_stimulus("word store", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check_output("word store const", mem[4], 32'hDEAD_BEEF);
        apply_stimulus("word load", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check_output("word load const", bus.dado_carregado, 32'hDEAD_BEEF);

        // Byte store merged into word 1.
        apply_stimulus("setup word1", 1'b1, 2'd2, 1'b0, 32'h04, 32'h1122_3344);
        apply_stimulus("byte store", 1'b1, 2'd0, 1'b0, 32'h06, 32'h0000_00AA);
        check_output("byte merge const", mem[1], 32'h11AA_3344);

        // Sign and zero extension on word 0 = 0x0080FF7F.
        apply_stimulus("setup word0", 1'b1, 2'd2, 1'b0, 32'h00, 32'h0080_FF7F);
        apply_stimulus("load byte sext", 1'b0, 2'd0, 1'b1, 32'h01, 32'h0);
        check_output("byte sext const", bus.dado_carregado, 32'hFFFF_FFFF);
        apply_stimulus("load byte zext", 1'b0, 2'd0, 1'b0, 32'h01, 32'h0);
        check_output("byte zext const", bus.dado_carregado, 32'h0000_00FF);
        apply_stimulus("load half sext", 1'b0, 2'd1, 1'b1, 32'h02, 32'h0);
        check_output("half sext const", bus.dado_carregado, 32'h0000_0080);

        // Back-to-back loads with req held; changes while busy must be ignored.
        exp1 = ref_mem[8];
        exp2 = ref_mem[9];
        bus.req = 1'b1; bus.op_escrita = 1'b0; bus.tamanho = 2'd2; bus.sinal = 1'b0;
        bus.endereco_byte = 32'h20;
        tick();
        bus.endereco_byte = 32'h24;
        check_output("b2b c1 ocupado", 32'(bus.ocupado), 32'd1);
        check_output("b2b c1 pronto", 32'(bus.pronto), 32'd0);
        tick();
        check_output("b2b c2 pronto", 32'(bus.pronto), 32'd1);
        check_output("b2b first data", bus.dado_carregado, exp1);
        tick();
        check_output("b2b c3 ocupado", 32'(bus.ocupado), 32'd0);
        check_output("b2b c3 pronto", 32'(bus.pronto), 32'd0);
        tick();
        check_output("b2b c4 ocupado", 32'(bus.ocupado), 32'd1);
        check_output("b2b c4 pronto", 32'(bus.pronto), 32'd0);
        tick();
        check_output("b2b c5 pronto", 32'(bus.pronto), 32'd1);
        check_output("b2b second data", bus.dado_carregado, exp2);
        bus.req   = 1'b0;
        last_load = exp2;
        tick();
        check_output("b2b idle ocupado", 32'(bus.ocupado), 32'd0);

        // Reset while a byte store sits in ESCRITA: the write must be suppressed.
        bus.req = 1'b1; bus.op_escrita = 1'b1; bus.tamanho = 2'd0; bus.sinal = 1'b0;
        bus.endereco_byte = 32'h15; bus.dado_cpu = 32'h0000_005A;
        tick();
        check_output("rst c1 mem_write", 32'(bus.mem_write), 32'd0);
        tick();
        check_output("rst c2 mem_write before reset", 32'(bus.mem_write), 32'd1);
        reset   = 1'b1;
        bus.req = 1'b0;
        #1;
        check_output("rst c2 mem_write gated", 32'(bus.mem_write), 32'd0);
        check_output("rst c2 pronto", 32'(bus.pronto), 32'd0);
        tick();
        reset = 1'b0;
        check_reset_values("after abort");
        check_output("abort memory", mem[5], ref_mem[5]);
        last_load = 32'h0;
        tick();
        check_output("abort no pronto", 32'(bus.pronto), 32'd0);

        // Misaligned word store: flagged with the check enabled, otherwise writes word 2.
        apply_stimulus("misaligned word", 1'b1, 2'd2, 1'b0, 32'h0A, 32'hCAFE_F00D);
`ifndef LS_ALIGN_CHECK_EN
        check_output("misaligned const", mem[2], 32'hCAFE_F00D);
`endif

        for (int i = 0; i < 60; i++) begin
            apply_stimulus($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
